// File: rtl/bcd_seq_ctrl.sv
// bcd_seq_ctrl: sequencing controller that owns a 4-bit BCD counter register.
// It steps the counter through one of three value sets (full 0..9, odd values
// above 3, or even values) under start/stop/pause control. A run lasts a
// programmable number of advances (0 = free-run) and ends with a one-cycle
// done pulse.
//
// Optional build macro BCD_SEQ_DOWN_EN adds a 'dir' input. It is sampled on an
// accepted start, and dir=1 selects descending sequences. Without the macro
// the block always counts upward.
//
// Handshake/command semantics: start, stop and pause are plain level inputs
// sampled on each rising edge. There is no ready back-pressure. The command
// priority on one edge is reset > stop > start > pause > advance. A start is
// accepted only in IDLE or DONE, and any start in RUN/HOLD is dropped.
// The FSM state is visible as the 'state' signal, for checkers to bind to.
module bcd_seq_ctrl #(
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
`ifdef BCD_SEQ_DOWN_EN
  input  logic              dir,
`endif
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic [1:0]        mode,
  input  logic [STEP_W-1:0] steps,
  output logic [3:0]        count,
  output logic              count_valid,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] MODE_FULL = 2'b00;
  localparam logic [1:0] MODE_ODD  = 2'b01;
  localparam logic [1:0] MODE_EVEN = 2'b10;
  localparam logic [1:0] MODE_BAD  = 2'b11;

  state_t            state, state_n;
  logic [1:0]        mode_q, mode_n;
  logic [STEP_W-1:0] steps_q, steps_n;
  logic [STEP_W-1:0] remaining, remaining_n;
  logic              dir_q, dir_n, dir_in;
  logic [3:0]        count_n;
  logic              valid_n, busy_n, done_n, err_n;

`ifdef BCD_SEQ_DOWN_EN
  assign dir_in = dir;
`else
  assign dir_in = 1'b0;
`endif

  // First value of a sequence. Descending runs start from the top of the set.
  function automatic logic [3:0] first_val(input logic [1:0] m, input logic down);
    logic [3:0] v;
    v = 4'd0;
    case (m)
      MODE_FULL: v = down ? 4'd9 : 4'd0;
      MODE_ODD:  v = down ? 4'd9 : 4'd5;
      MODE_EVEN: v = down ? 4'd8 : 4'd0;
      default:   v = 4'd0;
    endcase
    return v;
  endfunction

  // Successor within the latched set. Any value outside the set (for example
  // after an upset) falls through to the sequence's first value.
  function automatic logic [3:0] next_val(input logic [1:0] m, input logic down,
                                          input logic [3:0] c);
    logic [3:0] v;
    v = first_val(m, down);
    case (m)
      MODE_FULL: begin
        if (!down && c < 4'd9)                  v = c + 4'd1;
        else if (down && c >= 4'd1 && c <= 4'd9) v = c - 4'd1;
      end
      MODE_ODD: begin
        if (!down && c == 4'd5)      v = 4'd7;
        else if (!down && c == 4'd7) v = 4'd9;
        else if (down && c == 4'd9)  v = 4'd7;
        else if (down && c == 4'd7)  v = 4'd5;
      end
      MODE_EVEN: begin
        if (!down && !c[0] && c <= 4'd6)                  v = c + 4'd2;
        else if (down && !c[0] && c >= 4'd2 && c <= 4'd8) v = c - 4'd2;
      end
      default: v = 4'd0;
    endcase
    return v;
  endfunction

  // Next-state and next-output decode; every target defaults to its hold value.
  always_comb begin
    state_n     = state;
    mode_n      = mode_q;
    steps_n     = steps_q;
    remaining_n = remaining;
    dir_n       = dir_q;
    count_n     = count;
    valid_n     = count_valid;
    busy_n      = busy;
    done_n      = 1'b0;
    err_n       = err;

    if (stop) begin
      state_n = S_IDLE;
      count_n = 4'd0;
      valid_n = 1'b0;
      busy_n  = 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            if (mode == MODE_BAD) begin
              err_n = 1'b1;
            end else begin
              state_n     = S_RUN;
              mode_n      = mode;
              steps_n     = steps;
              remaining_n = steps;
              dir_n       = dir_in;
              count_n     = first_val(mode, dir_in);
              valid_n     = 1'b1;
              busy_n      = 1'b1;
              err_n       = 1'b0;
            end
          end
        end
        S_RUN: begin
          if (pause) begin
            state_n = S_HOLD;
          end else begin
            count_n = next_val(mode_q, dir_q, count);
            if (steps_q != '0) begin
              remaining_n = remaining - STEP_W'(1);
              if (remaining == STEP_W'(1)) begin
                state_n = S_DONE;
                busy_n  = 1'b0;
                done_n  = 1'b1;
              end
            end
          end
        end
        S_HOLD: begin
          // Leaving HOLD takes one edge of its own; advancing resumes after it.
          if (!pause) state_n = S_RUN;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // State and registered outputs, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      mode_q      <= 2'b00;
      steps_q     <= '0;
      remaining   <= '0;
      dir_q       <= 1'b0;
      count       <= 4'd0;
      count_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_n;
      mode_q      <= mode_n;
      steps_q     <= steps_n;
      remaining   <= remaining_n;
      dir_q       <= dir_n;
      count       <= count_n;
      count_valid <= valid_n;
      busy        <= busy_n;
      done        <= done_n;
      err         <= err_n;
    end
  end

endmodule
